instr_aligner: RTL

Instruction aligner between the fetch buffer and the decoder. It takes word-aligned 32-bit fetch words and produces one aligned instruction per cycle for the decoder, either RVI (32-bit) or RVC (16-bit). A 16-bit holding register carries a leftover upper halfword, so instructions can straddle two fetch words. The block also forwards fetch error codes, generates the align-error indication, and attributes predictor hits to the instruction that ends on the predicted halfword.

---
 rtl/instr_aligner.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instr_aligner.sv
// instr_aligner: turns word-aligned fetch words into one aligned RVI/RVC instruction per cycle
module instr_aligner (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_flush_i,
  input  logic        s_flush_hw_i,
  input  logic        s_fetch_valid_i,
  input  logic [31:0] s_fetch_data_i,
  input  logic [2:0]  s_fetch_error_i,
  input  logic        s_fetch_pred_i,
  input  logic        s_fetch_pred_hw_i,
  input  logic        s_fetch_pred_tgt_i,
  output logic        s_fetch_ready_o,
  input  logic        s_id_ready_i,
  output logic        s_valid_o,
  output logic [31:0] s_instr_o,
  output logic        s_prediction_o,
  output logic        s_align_error_o,
  output logic [2:0]  s_fetch_error_o
);
  localparam logic [2:0] FETCH_VALID = 3'b000;
  localparam logic [2:0] FETCH_INCER = 3'b001;
  logic        r_valid, r_pred, r_aerr, r_hold_v, r_hold_pred, r_start_hw;
  logic [31:0] r_instr;
  logic [2:0]  r_err, r_hold_err;
  logic [15:0] r_hold_hw;
  logic        w_adv, w_take, w_hold_c, w_lo_c, w_up_c, w_word_ok, w_pred_lo, w_pred_up;
  logic [15:0] w_lo, w_up;
  logic [2:0]  w_st_err;
  logic        w_emit, w_pred, w_aerr, w_hold_v, w_hold_pred, w_start, w_place, w_slot;
  logic [31:0] w_instr;
  logic [2:0]  w_err, w_hold_err;
  logic [15:0] w_hold_hw;
  assign w_lo            = s_fetch_data_i[15:0];
  assign w_up            = s_fetch_data_i[31:16];
  assign w_lo_c          = w_lo[1:0] != 2'b11;
  assign w_up_c          = w_up[1:0] != 2'b11;
  assign w_hold_c        = r_hold_hw[1:0] != 2'b11;
  assign w_word_ok       = (s_fetch_error_i == FETCH_VALID) | (s_fetch_error_i == FETCH_INCER);
  assign w_pred_lo       = s_fetch_pred_i & ~s_fetch_pred_hw_i;
  assign w_pred_up       = s_fetch_pred_i & s_fetch_pred_hw_i;
  assign w_st_err        = (r_hold_err != FETCH_VALID) ? r_hold_err : s_fetch_error_i;
  assign w_adv           = ~r_valid | s_id_ready_i;
  // a held halfword that must drain on its own (RVC, or carrying a prediction) blocks the next word
  assign s_fetch_ready_o = w_adv & ~s_flush_i & ~(r_hold_v & (w_hold_c | r_hold_pred));
  assign w_take          = s_fetch_valid_i & s_fetch_ready_o;
  assign s_valid_o       = r_valid;
  assign s_instr_o       = r_instr;
  assign s_prediction_o  = r_pred;
  assign s_align_error_o = r_aerr;
  assign s_fetch_error_o = r_err;
  // Choose the instruction emitted this cycle and the next holding/start state; the leftover upper halfword is placed last
  always_comb begin
    w_emit      = 1'b0;
    w_instr     = r_instr;
    w_err       = r_err;
    w_pred      = 1'b0;
    w_aerr      = 1'b0;
    w_hold_v    = r_hold_v;
    w_hold_hw   = r_hold_hw;
    w_hold_err  = r_hold_err;
    w_hold_pred = r_hold_pred;
    w_start     = r_start_hw;
    w_place     = 1'b0;
    w_slot      = 1'b0;
    if (r_hold_v && (w_hold_c || r_hold_pred)) begin
      w_emit      = 1'b1;
      w_instr     = {16'h0000, r_hold_hw};
      w_err       = r_hold_err;
      w_pred      = r_hold_pred & w_hold_c;
      w_aerr      = r_hold_pred & ~w_hold_c;
      w_hold_v    = 1'b0;
      w_hold_pred = 1'b0;
    end else if (w_take) begin
      w_hold_v    = 1'b0;
      w_hold_pred = 1'b0;
      w_emit      = 1'b1;
      w_err       = s_fetch_error_i;
      if (!w_word_ok) begin
        w_instr = s_fetch_data_i;
        w_start = 1'b0;
      end else if (r_hold_v) begin
        w_instr = {w_lo, r_hold_hw};
        w_err   = w_st_err;
        w_pred  = w_pred_lo;
        w_place = ~w_pred_lo;
        w_slot  = 1'b1;
        w_start = w_pred_lo ? s_fetch_pred_tgt_i : r_start_hw;
      end else if (!r_start_hw) begin
        w_instr = w_lo_c ? {16'h0000, w_lo} : s_fetch_data_i;
        w_pred  = w_lo_c ? w_pred_lo : w_pred_up;
        w_aerr  = ~w_lo_c & w_pred_lo;
        w_place = w_lo_c & ~w_pred_lo;
        w_slot  = 1'b1;
        w_start = (s_fetch_pred_i && !w_place) ? s_fetch_pred_tgt_i : r_start_hw;
      end else begin
        w_emit  = w_pred_lo;
        w_instr = {16'h0000, w_lo};
        w_aerr  = w_pred_lo;
        w_place = ~w_pred_lo;
        w_start = w_pred_lo ? s_fetch_pred_tgt_i : 1'b0;
      end
    end
    if (w_place) begin
      if (w_up_c && !w_slot) begin
        w_emit  = 1'b1;
        w_instr = {16'h0000, w_up};
        w_pred  = w_pred_up;
      end else begin
        w_hold_v    = 1'b1;
        w_hold_hw   = w_up;
        w_hold_err  = s_fetch_error_i;
        w_hold_pred = w_pred_up;
      end
      w_start = w_pred_up ? s_fetch_pred_tgt_i : w_start;
    end
  end
  // Output register and aligner state; flush outranks everything, nothing moves without advance
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_valid     <= 1'b0;
      r_instr     <= 32'h0;
      r_pred      <= 1'b0;
      r_aerr      <= 1'b0;
      r_err       <= FETCH_VALID;
      r_hold_v    <= 1'b0;
      r_hold_hw   <= 16'h0;
      r_hold_err  <= FETCH_VALID;
      r_hold_pred <= 1'b0;
      r_start_hw  <= 1'b0;
    end else if (s_flush_i) begin
      r_valid     <= 1'b0;
      r_hold_v    <= 1'b0;
      r_hold_pred <= 1'b0;
      r_start_hw  <= s_flush_hw_i;
    end else if (w_adv) begin
      r_valid     <= w_emit;
      r_instr     <= w_instr;
      r_pred      <= w_pred;
      r_aerr      <= w_aerr;
      r_err       <= w_err;
      r_hold_v    <= w_hold_v;
      r_hold_hw   <= w_hold_hw;
      r_hold_err  <= w_hold_err;
      r_hold_pred <= w_hold_pred;
      r_start_hw  <= w_start;
    end
  end
endmodule
